cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
// - Two-level (L1/L2) cache controller in front of an internal byte-wide main memory.
// - Serves one read or write request per clock. Reports whether the request hit in L1 or in L2.
// - Returns the byte read, or the byte written.
// - Used as a self-contained memory-hierarchy block; no external memory interface.
// PARAMETERS
// - ADDR_W    11  byte address width; main memory depth = 2**ADDR_W bytes
// - DATA_W    8   data byte width
// - OFFSET_W  2   byte-in-line offset bits; line = 2**OFFSET_W bytes
// - L1_IDX_W  3   L1 index bits (8 lines); must be <= L2_IDX_W
// - L2_IDX_W  4   L2 index bits (16 lines)
// PORTS
// - clk          in   1       clock; all state updates on the rising edge
// - rst_n        in   1       synchronous, active-low reset
// - address      in   ADDR_W  byte address of the request
// - data         in   DATA_W  write data; ignored when mode=0
// - mode         in   1       1 = write, 0 = read; a request is issued every cycle
// - output_data  out  DATA_W  read byte (read) or written byte (write)
// - hit1         out  1       request hit in L1
// - hit2         out  1       request missed L1 and hit in L2
// BEHAVIOUR
// - Address split: offset = address[OFFSET_W-1:0].
//   - L1 index = address[OFFSET_W+L1_IDX_W-1:OFFSET_W]; L1 tag = the remaining upper bits.
//   - L2 index and L2 tag are formed the same way using L2_IDX_W.
// - Both caches are direct-mapped. Each line holds a valid bit, a tag and 2**OFFSET_W data bytes.
// - Timing: the request is sampled at the rising edge.
//   - Lookup, hit flags, data and all array updates complete on that same edge.
//   - Outputs are registered and hold until the next edge (1-cycle latency).
// - Hit flags are computed from the array contents before this edge's update.
//   - hit1 and hit2 are never both 1.
//   - hit1=hit2=0 means the request was served by main memory.
// - Read, L1 hit: output_data = L1 byte; no array changes.
// - Read, L2 hit: output_data = L2 byte; copy the L2 line into L1 (overwrites the L1 victim).
// - Read, miss: output_data = memory byte; fill the line from memory into both L2 and L1.
// - Write policy is write-through with write-allocate:
//   - Memory byte is always written.
//   - If the line is present in L1 or L2, update that byte in place.
//   - On L1 miss, allocate the line into L1 from L2 (L2 hit) or from memory (miss), merged with the new byte.
//   - On L2 miss, likewise allocate the line into L2.
//   - output_data = data.
// - Evictions need no write-back, because memory is always current.
// - Reset (rst_n=0 at an edge):
//   - Clear all L1/L2 valid bits; hit1=0, hit2=0, output_data=0.
//   - The request in that cycle is dropped.
//   - Main memory is not reset; its power-up content is all-zero.
//   - Tag and data arrays are not reset.
// - Reset mid-sequence: previously cached lines miss afterwards, but their data is returned from memory.
// CONFIGURATION
// - Macro CACHE_STATS_EN. When defined, three extra output ports are added, each 16 bits, saturating at 0xFFFF:
//   - l1_hit_cnt, l2_hit_cnt, miss_cnt.
//   - The counters increment on every non-reset request according to its hit1/hit2/miss classification.
//   - Reset clears them to 0.
// - When CACHE_STATS_EN is undefined, the ports and counters do not exist and behaviour is otherwise identical.
// STRUCTURE
// - Package cache_controller_pkg holds:
//   - width constants (ADDR_W, DATA_W, OFFSET_W, L1_IDX_W, L2_IDX_W);
//   - MODE_READ=1'b0 and MODE_WRITE=1'b1;
//   - a line typedef {valid, tag, bytes}.
// - Sub-module cache_dm_array: a direct-mapped tag/data array, parameterised by index width.
//   - Ports: lookup, hit, line read, line write, byte write, invalidate-all.
//   - Instantiated twice, once as L1 and once as L2.
// - Top level holds main memory, control logic and output registers.
// TESTING
// - Reset, then read 0x02E -> hit1=0, hit2=0, output_data=0x00.
// - Write 0x41D data 0x0E, then read 0x41D -> read returns hit1=1, output_data=0x0E; the write itself reports hit1=0, hit2=0.
// - Read 0x10D, read 0x12D (same L1 index, different L2 index), read 0x10D -> last read returns hit1=0, hit2=1.
// - Write 0x12D 0x08, write 0x52D 0x09 (evicts in L1 and L2), read 0x12D -> hit1=0, hit2=0, output_data=0x08.
// - Write 0x32E 0x06, pulse rst_n low for 1 cycle, read 0x32E -> hit1=0, hit2=0, output_data=0x06.
// - With CACHE_STATS_EN: after the preceding scenario, counters match the counted hit/miss classifications; reset zeroes them.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared widths, mode encodings, line type and helpers for the L1/L2 cache controller.
package cache_controller_pkg;

   localparam int ADDR_W      = 11;
   localparam int DATA_W      = 8;
   localparam int OFFSET_W    = 2;
   localparam int L1_IDX_W    = 3;
   localparam int L2_IDX_W    = 4;

   localparam int LINE_BYTES  = 2 ** OFFSET_W;
   localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;
   // The L1 tag is the widest tag because L1 has the fewest index bits.
   localparam int TAG_MAX_W   = LINE_ADDR_W - L1_IDX_W;
   localparam int CNT_W       = 16;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   typedef logic [LINE_BYTES-1:0][DATA_W-1:0] line_bytes_t;

   // One cache line as seen at an array's lookup port; narrower tags are zero-extended.
   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      line_bytes_t          bytes;
   } line_t;

   // Saturating increment used by the optional statistics counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] res;
      if (v == {CNT_W{1'b1}}) begin
         res = v;
      end else begin
         res = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/cache_controller_dm_array.sv
// Direct-mapped tag/data array. The lookup address also selects the line that
// a line write or byte write updates. Valid bits clear together on i_inv_all;
// tags and data are never reset.
module cache_dm_array
   import cache_controller_pkg::*;
#(
   parameter int IDX_W = L1_IDX_W
) (
   input  logic                   clk,
   input  logic                   i_inv_all,
   input  logic [LINE_ADDR_W-1:0] i_line_addr,
   output logic                   o_hit,
   output line_t                  o_line,
   input  logic                   i_line_we,
   input  line_bytes_t            i_line_data,
   input  logic                   i_byte_we,
   input  logic [OFFSET_W-1:0]    i_byte_off,
   input  logic [DATA_W-1:0]      i_byte_data
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam int TAG_W = LINE_ADDR_W - IDX_W;

   logic [DEPTH-1:0] r_valid;
   logic [TAG_W-1:0] r_tag   [DEPTH];
   line_bytes_t      r_bytes [DEPTH];

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;

   assign w_idx = i_line_addr[IDX_W-1:0];
   assign w_tag = i_line_addr[LINE_ADDR_W-1:IDX_W];
   assign o_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

   // Present the indexed line with its tag zero-extended to the shared line type.
   always_comb begin
      o_line                = '{valid: 1'b0, tag: {TAG_MAX_W{1'b0}}, bytes: r_bytes[w_idx]};
      o_line.valid          = r_valid[w_idx];
      o_line.tag[TAG_W-1:0] = r_tag[w_idx];
   end

   // Valid bits: clear all on invalidate, set on a line fill.
   always_ff @(posedge clk) begin
      if (i_inv_all) begin
         r_valid <= {DEPTH{1'b0}};
      end else if (i_line_we) begin
         r_valid[w_idx] <= 1'b1;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Tag and data storage: whole-line fill or single-byte update in place.
   always_ff @(posedge clk) begin
      if (i_line_we) begin
         r_tag[w_idx]   <= w_tag;
         r_bytes[w_idx] <= i_line_data;
      end else if (i_byte_we) begin
         r_bytes[w_idx][i_byte_off] <= i_byte_data;
      end
   end

endmodule

// File: rtl/cache_controller.sv
// Two-level direct-mapped cache (L1/L2) in front of an internal byte-wide main
// memory. Write-through with write-allocate; one request per clock, outputs
// registered with one cycle of latency.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters.
module cache_controller
   import cache_controller_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic              mode,
   output logic [DATA_W-1:0] output_data,
   output logic              hit1,
   output logic              hit2
`ifdef CACHE_STATS_EN
   ,
   output logic [CNT_W-1:0]  l1_hit_cnt,
   output logic [CNT_W-1:0]  l2_hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
`endif
);

   // Main memory: never reset, powers up as all-zero.
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   logic [DATA_W-1:0] r_output_data;
   logic              r_hit1;
   logic              r_hit2;

   logic [LINE_ADDR_W-1:0] w_line_addr;
   logic [OFFSET_W-1:0]    w_off;
   logic                   w_inv_all;
   logic                   w_l1_hit;
   logic                   w_l2_hit_raw;
   logic                   w_hit2;
   line_t                  w_l1_line;
   line_t                  w_l2_line;
   line_bytes_t            w_mem_line;
   line_bytes_t            w_fill_line;
   logic                   w_l1_line_we;
   logic                   w_l1_byte_we;
   logic                   w_l2_line_we;
   logic                   w_l2_byte_we;
   logic                   w_mem_we;
   logic [DATA_W-1:0]      w_rdata;

   assign w_line_addr = address[ADDR_W-1:OFFSET_W];
   assign w_off       = address[OFFSET_W-1:0];
   assign w_inv_all   = !rst_n;
   // L2 only counts as a hit when L1 missed, so the two flags are exclusive.
   assign w_hit2      = !w_l1_hit && w_l2_hit_raw;

   for (genvar g = 0; g < LINE_BYTES; g++) begin : g_mem_line
      assign w_mem_line[g] = r_mem[{w_line_addr, OFFSET_W'(g)}];
   end

   cache_dm_array #(.IDX_W(L1_IDX_W)) u_l1 (
      .clk         (clk),
      .i_inv_all   (w_inv_all),
      .i_line_addr (w_line_addr),
      .o_hit       (w_l1_hit),
      .o_line      (w_l1_line),
      .i_line_we   (w_l1_line_we),
      .i_line_data (w_fill_line),
      .i_byte_we   (w_l1_byte_we),
      .i_byte_off  (w_off),
      .i_byte_data (data)
   );

   cache_dm_array #(.IDX_W(L2_IDX_W)) u_l2 (
      .clk         (clk),
      .i_inv_all   (w_inv_all),
      .i_line_addr (w_line_addr),
      .o_hit       (w_l2_hit_raw),
      .o_line      (w_l2_line),
      .i_line_we   (w_l2_line_we),
      .i_line_data (w_fill_line),
      .i_byte_we   (w_l2_byte_we),
      .i_byte_off  (w_off),
      .i_byte_data (data)
   );

   // Request decode: choose the data source, the fill line and the array/memory write enables.
   always_comb begin
      w_l1_line_we = 1'b0;
      w_l1_byte_we = 1'b0;
      w_l2_line_we = 1'b0;
      w_l2_byte_we = 1'b0;
      w_mem_we     = 1'b0;
      w_rdata      = w_mem_line[w_off];
      // Fills come from L2 when it holds the line, otherwise from memory.
      w_fill_line  = w_l2_hit_raw ? w_l2_line.bytes : w_mem_line;
      if (rst_n) begin
         case (mode)
            MODE_WRITE: begin
               w_mem_we            = 1'b1;
               w_fill_line[w_off]  = data;
               w_l1_byte_we        = w_l1_hit;
               w_l1_line_we        = !w_l1_hit;
               w_l2_byte_we        = w_l2_hit_raw;
               w_l2_line_we        = !w_l2_hit_raw;
               w_rdata             = data;
            end
            MODE_READ: begin
               if (w_l1_hit) begin
                  w_rdata = w_l1_line.bytes[w_off];
               end else if (w_l2_hit_raw) begin
                  w_rdata      = w_l2_line.bytes[w_off];
                  w_l1_line_we = 1'b1;
               end else begin
                  w_rdata      = w_mem_line[w_off];
                  w_l1_line_we = 1'b1;
                  w_l2_line_we = 1'b1;
               end
            end
            default: begin
               w_rdata = {DATA_W{1'b0}};
            end
         endcase
      end else begin
         w_rdata = {DATA_W{1'b0}};
      end
   end

   // Main memory write port: every accepted write goes through to memory.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[address] <= data;
      end
   end

   // Registered request result: data byte and hit classification.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_output_data <= {DATA_W{1'b0}};
         r_hit1        <= 1'b0;
         r_hit2        <= 1'b0;
      end else begin
         r_output_data <= w_rdata;
         r_hit1        <= w_l1_hit;
         r_hit2        <= w_hit2;
      end
   end

   assign output_data = r_output_data;
   assign hit1        = r_hit1;
   assign hit2        = r_hit2;

`ifdef CACHE_STATS_EN
   logic [CNT_W-1:0] r_l1_hit_cnt;
   logic [CNT_W-1:0] r_l2_hit_cnt;
   logic [CNT_W-1:0] r_miss_cnt;

   // Statistics: classify each accepted request as L1 hit, L2 hit or miss.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_l1_hit_cnt <= {CNT_W{1'b0}};
         r_l2_hit_cnt <= {CNT_W{1'b0}};
         r_miss_cnt   <= {CNT_W{1'b0}};
      end else if (w_l1_hit) begin
         r_l1_hit_cnt <= sat_inc(r_l1_hit_cnt);
      end else if (w_hit2) begin
         r_l2_hit_cnt <= sat_inc(r_l2_hit_cnt);
      end else begin
         r_miss_cnt   <= sat_inc(r_miss_cnt);
      end
   end

   assign l1_hit_cnt = r_l1_hit_cnt;
   assign l2_hit_cnt = r_l2_hit_cnt;
   assign miss_cnt   = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus random
// traffic compared every cycle against a line-presence model of the hierarchy.
`timescale 1ns/1ps
module tb_cache_controller;
   import cache_controller_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] address = 11'd0;
   logic [DATA_W-1:0] data = 8'd0;
   logic              mode = 1'b0;
   logic [DATA_W-1:0] output_data;
   logic              hit1;
   logic              hit2;
`ifdef CACHE_STATS_EN
   logic [15:0]       l1_hit_cnt;
   logic [15:0]       l2_hit_cnt;
   logic [15:0]       miss_cnt;
`endif

   cache_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .address     (address),
      .data        (data),
      .mode        (mode),
      .output_data (output_data),
      .hit1        (hit1),
      .hit2        (hit2)
`ifdef CACHE_STATS_EN
      ,
      .l1_hit_cnt  (l1_hit_cnt),
      .l2_hit_cnt  (l2_hit_cnt),
      .miss_cnt    (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Model: memory contents plus which line address sits in each cache slot.
   // Write-through keeps every cached copy equal to memory, so data comes from m_mem.
   logic [7:0] m_mem [2048];
   bit         m_l1_v [8];
   int         m_l1_ln [8];
   bit         m_l2_v [16];
   int         m_l2_ln [16];
   int         m_c1, m_c2, m_cm;

   // Expectation for the request being driven, then latched at the sampling edge.
   logic [7:0] p_d,  e_d;
   bit         p_h1, e_h1, p_h2, e_h2;
   int         p_c1, e_c1, p_c2, e_c2, p_cm, e_cm;
   bit         p_valid = 1'b0, e_valid = 1'b0;
   bit         p_lit = 1'b0, e_lit = 1'b0;
   logic [7:0] p_ld, e_ld;
   bit         p_lh1, e_lh1, p_lh2, e_lh2;
   int         p_id, e_id;

   int checks = 0;
   int errors = 0;

   always @(posedge clk) begin
      e_valid <= p_valid; e_d <= p_d; e_h1 <= p_h1; e_h2 <= p_h2;
      e_c1 <= p_c1; e_c2 <= p_c2; e_cm <= p_cm;
      e_lit <= p_lit; e_ld <= p_ld; e_lh1 <= p_lh1; e_lh2 <= p_lh2; e_id <= p_id;
   end

   // Single compare process: model every cycle, literal expectations when set.
   always @(negedge clk) begin
      if (e_valid) begin
         checks = checks + 1;
         if (output_data !== e_d) begin
            errors = errors + 1;
            $display("FAIL data t=%0t got %02h want %02h", $time, output_data, e_d);
         end
         checks = checks + 1;
         if (hit1 !== e_h1 || hit2 !== e_h2) begin
            errors = errors + 1;
            $display("FAIL hits t=%0t got %0b%0b want %0b%0b", $time, hit1, hit2, e_h1, e_h2);
         end
`ifdef CACHE_STATS_EN
         checks = checks + 1;
         if (l1_hit_cnt !== 16'(e_c1) || l2_hit_cnt !== 16'(e_c2) || miss_cnt !== 16'(e_cm)) begin
            errors = errors + 1;
            $display("FAIL stats t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                     l1_hit_cnt, l2_hit_cnt, miss_cnt, e_c1, e_c2, e_cm);
         end
`endif
         if (e_lit) begin
            checks = checks + 1;
            if (output_data !== e_ld || hit1 !== e_lh1 || hit2 !== e_lh2) begin
               errors = errors + 1;
               $display("FAIL lit%0d got d=%02h h=%0b%0b want d=%02h h=%0b%0b", e_id,
                        output_data, hit1, hit2, e_ld, e_lh1, e_lh2);
            end
         end
      end
   end

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   // Drive one request, advance the model, then wait until its result is registered.
   task automatic req(input bit rst, input int a, input logic [7:0] d, input bit wr,
                      input bit lit, input int id, input bit lh1, input bit lh2,
                      input logic [7:0] ld);
      int ln, i1, i2;
      bit h1, h2;
      rst_n   = !rst;
      address = a[10:0];
      data    = d;
      mode    = wr;
      ln = (a & 2047) >> 2;
      i1 = ln % 8;
      i2 = ln % 16;
      h1 = m_l1_v[i1] && (m_l1_ln[i1] == ln);
      h2 = !h1 && m_l2_v[i2] && (m_l2_ln[i2] == ln);
      if (rst) begin
         p_d = 8'd0; p_h1 = 1'b0; p_h2 = 1'b0;
         for (int k = 0; k < 8; k++) m_l1_v[k] = 1'b0;
         for (int k = 0; k < 16; k++) m_l2_v[k] = 1'b0;
         m_c1 = 0; m_c2 = 0; m_cm = 0;
      end else begin
         p_d  = wr ? d : m_mem[a & 2047];
         p_h1 = h1;
         p_h2 = h2;
         if (wr) m_mem[a & 2047] = d;
         m_l1_v[i1] = 1'b1; m_l1_ln[i1] = ln;
         if (wr || !h1) begin
            m_l2_v[i2] = 1'b1; m_l2_ln[i2] = ln;
         end
         if (h1) m_c1 = sat(m_c1);
         else if (h2) m_c2 = sat(m_c2);
         else m_cm = sat(m_cm);
      end
      p_c1 = m_c1; p_c2 = m_c2; p_cm = m_cm;
      p_valid = 1'b1;
      p_lit = lit; p_id = id; p_lh1 = lh1; p_lh2 = lh2; p_ld = ld;
      @(posedge clk);
      #2;
   endtask

   initial begin
      for (int k = 0; k < 2048; k++) m_mem[k] = 8'd0;
      for (int k = 0; k < 8; k++) begin m_l1_v[k] = 1'b0; m_l1_ln[k] = 0; end
      for (int k = 0; k < 16; k++) begin m_l2_v[k] = 1'b0; m_l2_ln[k] = 0; end
      m_c1 = 0; m_c2 = 0; m_cm = 0;
      @(posedge clk);
      #2;
      // Reset state, then a cold read of never-written memory.
      req(1'b1, 0,       8'h00, 1'b0, 1'b1, 1,  1'b0, 1'b0, 8'h00);
      req(1'b0, 'h02E,   8'h5A, 1'b0, 1'b1, 2,  1'b0, 1'b0, 8'h00);
      // Write-allocate then L1 read hit.
      req(1'b0, 'h41D,   8'h0E, 1'b1, 1'b1, 3,  1'b0, 1'b0, 8'h0E);
      req(1'b0, 'h41D,   8'h00, 1'b0, 1'b1, 4,  1'b1, 1'b0, 8'h0E);
      // L1 conflict with distinct L2 slots gives an L2 hit.
      req(1'b0, 'h10D,   8'h00, 1'b0, 1'b1, 5,  1'b0, 1'b0, 8'h00);
      req(1'b0, 'h12D,   8'h00, 1'b0, 1'b1, 6,  1'b0, 1'b0, 8'h00);
      req(1'b0, 'h10D,   8'h00, 1'b0, 1'b1, 7,  1'b0, 1'b1, 8'h00);
      // Eviction from both levels still returns the written byte from memory.
      req(1'b0, 'h12D,   8'h08, 1'b1, 1'b1, 8,  1'b0, 1'b1, 8'h08);
      req(1'b0, 'h52D,   8'h09, 1'b1, 1'b1, 9,  1'b0, 1'b0, 8'h09);
      req(1'b0, 'h12D,   8'h00, 1'b0, 1'b1, 10, 1'b0, 1'b0, 8'h08);
      // Reset mid-sequence: line misses but memory keeps the data.
      req(1'b0, 'h32E,   8'h06, 1'b1, 1'b1, 11, 1'b0, 1'b0, 8'h06);
      req(1'b1, 'h32E,   8'hFF, 1'b1, 1'b1, 12, 1'b0, 1'b0, 8'h00);
      req(1'b0, 'h32E,   8'h00, 1'b0, 1'b1, 13, 1'b0, 1'b0, 8'h06);
      req(1'b0, 'h32E,   8'h00, 1'b0, 1'b1, 14, 1'b1, 1'b0, 8'h06);
      // Random traffic, half of it confined to a small aliasing address set.
      for (int n = 0; n < 3000; n++) begin
         int a;
         bit r;
         a = int'($urandom_range(0, 2047));
         if ($urandom_range(0, 1) == 1) a = a & 'h23F;
         r = ($urandom_range(0, 99) == 0);
         req(r, a, 8'($urandom), 1'($urandom), 1'b0, 0, 1'b0, 1'b0, 8'h00);
      end
      rst_n = 1'b0;
      p_valid = 1'b0;
      #10;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
